// File: rtl/cordic_atan2.sv
// Vectoring-mode CORDIC: atan2(y, x) and K-corrected magnitude of a signed
// fixed-point vector, one micro-rotation per clock.
module cordic_atan2 #(
  parameter int WIDTH      = 32,
  parameter int FPSHIFT    = 28,
  parameter int ITERATIONS = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] angle,
  output logic signed [WIDTH-1:0] magnitude
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_ITER  = 2'd2;
  localparam logic [1:0] S_SCALE = 2'd3;

  localparam int  IW     = $clog2(ITERATIONS);
  localparam real FP_ONE = 2.0 ** FPSHIFT;
  localparam logic signed [WIDTH-1:0] PI_FP = WIDTH'($rtoi(3.14159265358979323846 * FP_ONE + 0.5));
  localparam logic signed [WIDTH-1:0] K_FP  = WIDTH'($rtoi(0.6072529350 * FP_ONE + 0.5));
  localparam logic [IW-1:0] LAST_I = IW'(ITERATIONS - 1);

  logic signed [WIDTH-1:0] atan_rom [ITERATIONS];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_rom
    localparam real ATAN_R = $atan(1.0 / (2.0 ** g));
    assign atan_rom[g] = WIDTH'($rtoi(ATAN_R * FP_ONE + 0.5));
  end

  logic [1:0]              state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [IW-1:0]           i_q, i_d;
  logic                    zero_q, zero_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] angle_q, angle_d, mag_q, mag_d;

  logic signed [WIDTH-1:0]   x_sh, y_sh;
  logic signed [2*WIDTH-1:0] prod;

  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;
  assign prod = (2*WIDTH)'(x_q) * (2*WIDTH)'(K_FP);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    angle_d = angle_q;
    mag_d   = mag_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          y_d     = y_in;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        i_d     = '0;
        state_d = S_ITER;
        // Fold the left half-plane onto the right so the rotations converge.
        if (x_q[WIDTH-1]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = y_q[WIDTH-1] ? -PI_FP : PI_FP;
        end else begin
          z_d = '0;
        end
      end
      S_ITER: begin
        if (!y_q[WIDTH-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_rom[i_q];
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_rom[i_q];
        end
        i_d = i_q + 1'b1;
        if (i_q == LAST_I) state_d = S_SCALE;
      end
      S_SCALE: begin
        // A zero vector still rotates z through every table entry; report 0.
        angle_d = zero_q ? '0 : z_q;
        mag_d   = WIDTH'(prod >>> FPSHIFT);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign angle     = angle_q;
  assign magnitude = mag_q;

endmodule

// File: tb/tb_cordic_atan2.sv
// Bench for cordic_atan2: real-math reference with a cycle-level acceptance
// model, directed corner cases and randomized traffic.
module tb_cordic_atan2;
  localparam int W    = 32;
  localparam int FP   = 28;
  localparam int IT   = 24;
  localparam int LAT  = IT + 2;
  localparam int TOL  = 512;
  localparam int ONE  = 1 << FP;
  localparam int TWO  = 1 << (FP + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_in = '0;
  logic                busy, done;
  logic signed [W-1:0] angle, magnitude;

  always #5 clk = ~clk;

  cordic_atan2 #(.WIDTH(W), .FPSHIFT(FP), .ITERATIONS(IT)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .angle(angle), .magnitude(magnitude)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  bit pending = 1'b0;
  int done_at = 0;
  int job_ang = 0, job_mag = 0;
  int m_ang = 0, m_mag = 0;
  bit m_busy = 1'b0, m_done = 1'b0;

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  function automatic void ref_model(input int x, input int y, output int a, output int m);
    real xr, yr;
    xr = $itor(x);
    yr = $itor(y);
    if (x == 0 && y == 0) a = 0;
    else a = rnd($atan2(yr, xr) * (2.0 ** FP));
    m = rnd($sqrt(xr * xr + yr * yr));
  endfunction

  function automatic bit near(input longint a, input longint b);
    longint d;
    d = a - b;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a request is taken when no job is outstanding; results appear
  // LAT edges later and hold until the next completion or a reset.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pending = 1'b0;
      m_done  = 1'b0;
      m_ang   = 0;
      m_mag   = 0;
    end else begin
      m_done = 1'b0;
      if (pending && cyc == done_at) begin
        pending = 1'b0;
        m_done  = 1'b1;
        m_ang   = job_ang;
        m_mag   = job_mag;
      end else if (!pending && start) begin
        ref_model(x_in, y_in, job_ang, job_mag);
        pending = 1'b1;
        done_at = cyc + LAT;
      end
    end
    m_busy = pending;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy === m_busy, busy, m_busy);
      check("done", done === m_done, done, m_done);
      check("angle", !$isunknown(angle) && near(angle, m_ang), angle, m_ang);
      check("magnitude", !$isunknown(magnitude) && near(magnitude, m_mag), magnitude, m_mag);
    end
  end

  task automatic run_op(input int x, input int y, input string tag, input int ea, input int em);
    int n;
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < LAT + 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n == LAT, n, LAT);
    check({tag, " angle"}, near(angle, ea), angle, ea);
    check({tag, " magnitude"}, near(magnitude, em), magnitude, em);
    check({tag, " model angle"}, near(m_ang, ea), m_ang, ea);
  endtask

  function automatic int rand_coord();
    int sel;
    sel = int'($urandom_range(0, 15));
    case (sel)
      0: return 0;
      1: return ONE;
      2: return -ONE;
      3: return TWO;
      4: return -TWO;
      default: return int'($urandom_range(0, 2 * TWO)) - TWO;
    endcase
  endfunction

  initial begin
    int n;
    int seen;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", busy === 1'b0, busy, 0);
    check("reset done", done === 1'b0, done, 0);
    check("reset angle", angle === '0, angle, 0);
    check("reset magnitude", magnitude === '0, magnitude, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(ONE, 0, "x1y0", 0, ONE);
    run_op(ONE, ONE, "x1y1", 210828714, 379625062);
    run_op(-ONE, 0, "xm1y0", 843314857, ONE);
    run_op(-ONE, -ONE, "xm1ym1", -632486143, 379625062);
    run_op(0, -ONE, "x0ym1", -421657428, ONE);
    run_op(0, 0, "x0y0", 0, 0);
    check("zero angle exact", angle === '0, angle, 0);
    check("zero magnitude exact", magnitude === '0, magnitude, 0);

    // Second request while busy must be dropped.
    x_in = ONE; y_in = ONE; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < LAT + 20) begin
      if (n == 4) begin
        start = 1'b1; x_in = -ONE; y_in = 0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("ignore latency", n == LAT, n, LAT);
    check("ignore angle", near(angle, 210828714), angle, 210828714);
    run_op(0, ONE, "done-cycle start", 421657428, ONE);

    // Reset mid-operation discards the job.
    @(negedge clk);
    x_in = ONE; y_in = ONE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy === 1'b0, busy, 0);
    check("abort done", done === 1'b0, done, 0);
    check("abort angle", angle === '0, angle, 0);
    check("abort magnitude", magnitude === '0, magnitude, 0);
    seen = 0;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort no done", seen == 0, seen, 0);
    run_op(-ONE, ONE, "after abort", 632486143, 379625062);

    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(0, 3) == 0);
      x_in  = rand_coord();
      y_in  = rand_coord();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
